// File: rtl/mii_pkg.sv
// Shared definitions for the MII byte generator and the 64-bit byte packer.
package mii_pkg;

   // Control character codes on the 8-bit MII side
   localparam logic [7:0] MII_IDLE  = 8'h07;
   localparam logic [7:0] MII_START = 8'hFB;
   localparam logic [7:0] MII_TERM  = 8'hFD;
   localparam logic [7:0] MII_ERROR = 8'hFE;

   // Lane geometry of the packed word
   localparam int LANE_BITS  = 8;
   localparam int NUM_LANES  = 8;
   localparam int LANE_IDX_W = 3;

   // Frame tracking state of the packer
   typedef enum logic {
      LINK_IDLE = 1'b0,
      IN_FRAME  = 1'b1
   } link_state_t;

   // Upstream byte generator state, kept here so both blocks share one source
   typedef enum logic [1:0] {
      GEN_IDLE  = 2'd0,
      GEN_START = 2'd1,
      GEN_DATA  = 2'd2,
      GEN_TERM  = 2'd3
   } state_t;

   // True when a control byte is one of the three characters the link defines
   function automatic logic is_known_ctrl(input logic [7:0] code,
                                          input logic [7:0] idle_code,
                                          input logic [7:0] start_code,
                                          input logic [7:0] term_code);
      return (code == idle_code) || (code == start_code) || (code == term_code);
   endfunction

endpackage

// File: rtl/mii_out_reg.sv
// One-entry valid/ready holding register. A word arriving while the held
// word is stalled is dropped and recorded in a sticky overflow flag.
module mii_out_reg #(
   parameter int                    DATA_WIDTH = 64,
   parameter int                    CTRL_WIDTH = DATA_WIDTH / 8,
   parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [CTRL_WIDTH-1:0] i_ctrl,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [CTRL_WIDTH-1:0] o_ctrl,
   output logic                  o_valid,
   output logic                  o_overflow
);

   logic [DATA_WIDTH-1:0] r_data;
   logic [CTRL_WIDTH-1:0] r_ctrl;
   logic                  r_valid;
   logic                  r_overflow;
   logic                  w_stalled;

   // The held word can only be replaced if it is empty or leaving this cycle
   assign w_stalled = r_valid && !i_ready;

   // Load, hold, or drop; data is never cleared so it stays stable when idle
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_data     <= RESET_DATA;
         r_ctrl     <= '1;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (i_load) begin
         if (w_stalled) begin
            r_overflow <= 1'b1;
         end else begin
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
            r_valid <= 1'b1;
         end
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data     = r_data;
   assign o_ctrl     = r_ctrl;
   assign o_valid    = r_valid;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/mii_byte_packer.sv
// Packs 8-bit MII bytes into DATA_WIDTH-bit words with per-lane control,
// realigning every START to lane 0 and tracking frame-level protocol errors.
module mii_byte_packer
   import mii_pkg::*;
#(
   parameter int         DATA_WIDTH     = 64,
   parameter int         CTRL_WIDTH     = DATA_WIDTH / 8,
   parameter logic [7:0] IDLE_CODE      = MII_IDLE,
   parameter logic [7:0] START_CODE     = MII_START,
   parameter logic [7:0] TERMINATE_CODE = MII_TERM,
   parameter logic [7:0] ERROR_CODE     = MII_ERROR
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [7:0]            i_tx_data,
   input  logic                  i_tx_ctrl,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [CTRL_WIDTH-1:0] o_ctrl,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_overflow,
   output logic                  o_proto_err
);

   localparam int                    LANE_W    = $clog2(CTRL_WIDTH);
   localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(CTRL_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{IDLE_CODE}};

   logic [DATA_WIDTH-1:0] r_acc_data;
   logic [CTRL_WIDTH-1:0] r_acc_ctrl;
   logic [LANE_W-1:0]     r_lane;
   link_state_t           r_state;
   logic                  r_proto_err;

   logic                  w_unknown;
   logic [7:0]            w_byte;
   logic                  w_is_start;
   logic                  w_is_term;
   logic                  w_is_idle;
   logic                  w_pad;
   logic                  w_done;
   logic                  w_violation;
   logic [DATA_WIDTH-1:0] w_word_data;
   logic [CTRL_WIDTH-1:0] w_word_ctrl;

   // Classify the incoming byte; unknown control codes become ERROR_CODE
   assign w_unknown  = i_tx_ctrl && !is_known_ctrl(i_tx_data, IDLE_CODE, START_CODE, TERMINATE_CODE);
   assign w_byte     = w_unknown ? ERROR_CODE : i_tx_data;
   assign w_is_start = i_tx_ctrl && (i_tx_data == START_CODE);
   assign w_is_term  = i_tx_ctrl && (i_tx_data == TERMINATE_CODE);
   assign w_is_idle  = i_tx_ctrl && (i_tx_data == IDLE_CODE);

   // A mid-word START flushes the partial word; lane 7 completes a full one
   assign w_pad  = i_valid && w_is_start && (r_lane != '0);
   assign w_done = i_valid && ((r_lane == LAST_LANE) || w_pad);

   // Completed word per lane: padding fills the unwritten tail with IDLE
   generate
      for (genvar gi = 0; gi < CTRL_WIDTH; gi++) begin : g_lane
         assign w_word_data[8*gi +: 8] =
            w_pad ? ((LANE_W'(gi) < r_lane) ? r_acc_data[8*gi +: 8] : IDLE_CODE)
                  : ((LANE_W'(gi) == r_lane) ? w_byte : r_acc_data[8*gi +: 8]);
         assign w_word_ctrl[gi] =
            w_pad ? ((LANE_W'(gi) < r_lane) ? r_acc_ctrl[gi] : 1'b1)
                  : ((LANE_W'(gi) == r_lane) ? i_tx_ctrl : r_acc_ctrl[gi]);
      end
   endgenerate

   // Lane accumulator: write the byte into the current lane or restart on START
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc_data <= IDLE_WORD;
         r_acc_ctrl <= '1;
         r_lane     <= '0;
      end else if (i_valid) begin
         if (w_pad) begin
            r_acc_data <= {{(CTRL_WIDTH-1){IDLE_CODE}}, START_CODE};
            r_acc_ctrl <= '1;
            r_lane     <= LANE_W'(1);
         end else begin
            r_acc_data[8*r_lane +: 8] <= w_byte;
            r_acc_ctrl[r_lane]        <= i_tx_ctrl;
            r_lane                    <= r_lane + 1'b1;
         end
      end
   end

   // Byte sequences that are illegal for the current frame state
   assign w_violation = w_unknown
                     || (w_is_start && (r_state == IN_FRAME))
                     || (w_is_term  && (r_state == LINK_IDLE))
                     || (!i_tx_ctrl && (r_state == LINK_IDLE))
                     || (w_is_idle  && (r_state == IN_FRAME));

   // Frame FSM with sticky protocol error flag
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= LINK_IDLE;
         r_proto_err <= 1'b0;
      end else if (i_valid) begin
         if (w_violation) begin
            r_proto_err <= 1'b1;
         end
         if (w_is_start) begin
            r_state <= IN_FRAME;
         end else if (w_is_term) begin
            r_state <= LINK_IDLE;
         end
      end
   end

   assign o_proto_err = r_proto_err;

   mii_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .CTRL_WIDTH (CTRL_WIDTH),
      .RESET_DATA (IDLE_WORD)
   ) u_out_reg (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_load     (w_done),
      .i_data     (w_word_data),
      .i_ctrl     (w_word_ctrl),
      .i_ready    (i_ready),
      .o_data     (o_data),
      .o_ctrl     (o_ctrl),
      .o_valid    (o_valid),
      .o_overflow (o_overflow)
   );

endmodule

// File: tb/tb_mii_byte_packer.sv
// Scoreboard bench for mii_byte_packer: each scenario queues the words it
// expects; a monitor pops and compares every word the DUT hands over.
module tb_mii_byte_packer;

   localparam logic [7:0] IDLE  = 8'h07;
   localparam logic [7:0] START = 8'hFB;
   localparam logic [7:0] TERM  = 8'hFD;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic [7:0]  i_tx_data = 8'h00;
   logic        i_tx_ctrl = 1'b0;
   logic [63:0] o_data;
   logic [7:0]  o_ctrl;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic        o_overflow;
   logic        o_proto_err;

   int errors = 0;
   int checks = 0;
   logic [71:0] exp_q[$];

   mii_byte_packer dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .i_tx_data   (i_tx_data),
      .i_tx_ctrl   (i_tx_ctrl),
      .o_data      (o_data),
      .o_ctrl      (o_ctrl),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_overflow  (o_overflow),
      .o_proto_err (o_proto_err)
   );

   always #5 clk = ~clk;

   // Monitor: a word transfers on the next edge whenever valid && ready here
   always @(negedge clk) begin
      logic [71:0] exp_w;
      if (!i_rst && o_valid && i_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got data=%h ctrl=%h required none", o_data, o_ctrl);
         end else begin
            exp_w = exp_q.pop_front();
            if ({o_data, o_ctrl} !== exp_w) begin
               errors++;
               $display("FAIL word got data=%h ctrl=%h required data=%h ctrl=%h",
                        o_data, o_ctrl, exp_w[71:8], exp_w[7:0]);
            end else begin
               $display("word data=%h ctrl=%h ok", o_data, o_ctrl);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic c);
      i_valid   = 1'b1;
      i_tx_data = d;
      i_tx_ctrl = c;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input logic [63:0] d, input logic [7:0] c);
      exp_q.push_back({d, c});
   endtask

   task automatic test_drain(input string name);
      wait_cycles(3);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL %s_missing_words got pending=%0d required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({o_data, o_ctrl, o_valid, o_overflow, o_proto_err} !== {64'h0707070707070707, 8'hFF, 3'b000}) begin
         errors++;
         $display("FAIL reset_state got data=%h ctrl=%h v=%b ov=%b pe=%b required 0707070707070707 ff 0 0 0",
                  o_data, o_ctrl, o_valid, o_overflow, o_proto_err);
      end
   endtask

   task automatic test_idle_word();
      expect_word(64'h0707070707070707, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         send_byte(IDLE, 1'b1);
         checks++;
         if (o_valid !== (i == 7)) begin
            errors++;
            $display("FAIL idle_latency byte=%0d got valid=%b required %b", i, o_valid, (i == 7));
         end
      end
      test_drain("idle_word");
   endtask

   task automatic test_start_lane0();
      expect_word(64'hAAAAAAAAAAAAAAFB, 8'h01);
      expect_word(64'h07070707070707FD, 8'hFF);
      send_byte(START, 1'b1);
      for (int i = 0; i < 7; i++) send_byte(8'hAA, 1'b0);
      send_byte(TERM, 1'b1);
      for (int i = 0; i < 7; i++) send_byte(IDLE, 1'b1);
      test_drain("start_lane0");
      checks++;
      if (o_proto_err !== 1'b0) begin
         errors++;
         $display("FAIL start_lane0_proto got %b required 0", o_proto_err);
      end
   endtask

   task automatic test_start_align();
      expect_word(64'h0707070707070707, 8'hFF);
      expect_word(64'hFDAAAAAAAAAAAAFB, 8'h81);
      for (int i = 0; i < 3; i++) send_byte(IDLE, 1'b1);
      send_byte(START, 1'b1);
      checks++;
      if (o_valid !== 1'b1) begin
         errors++;
         $display("FAIL align_pad_latency got valid=%b required 1", o_valid);
      end
      for (int i = 0; i < 6; i++) send_byte(8'hAA, 1'b0);
      send_byte(TERM, 1'b1);
      test_drain("start_align");
   endtask

   task automatic test_long_frame();
      expect_word(64'hAAAAAAAAAAAAAAFB, 8'h01);
      for (int w = 0; w < 4; w++) expect_word(64'hAAAAAAAAAAAAAAAA, 8'h00);
      expect_word(64'hFDAAAAAAAAAAAAAA, 8'h80);
      expect_word(64'h0707070707070707, 8'hFF);
      send_byte(START, 1'b1);
      for (int i = 0; i < 46; i++) send_byte(8'hAA, 1'b0);
      send_byte(TERM, 1'b1);
      for (int i = 0; i < 8; i++) send_byte(IDLE, 1'b1);
      test_drain("long_frame");
      checks++;
      if ({o_overflow, o_proto_err} !== 2'b00) begin
         errors++;
         $display("FAIL long_frame_flags got ov=%b pe=%b required 0 0", o_overflow, o_proto_err);
      end
   endtask

   task automatic test_back_to_back_overflow();
      expect_word(64'hAAAAAAAAAAAAAAFB, 8'h01);
      expect_word(64'h070707FDAAAAAAAA, 8'hF0);
      i_ready = 1'b0;
      send_byte(START, 1'b1);
      for (int i = 1; i < 20; i++) begin
         send_byte(8'hAA, 1'b0);
         if (i == 14 || i == 15) begin
            checks++;
            if (o_overflow !== (i == 15)) begin
               errors++;
               $display("FAIL overflow_edge byte=%0d got %b required %b", i, o_overflow, (i == 15));
            end
         end
      end
      checks++;
      if ({o_valid, o_data, o_ctrl} !== {1'b1, 64'hAAAAAAAAAAAAAAFB, 8'h01}) begin
         errors++;
         $display("FAIL held_word got v=%b data=%h ctrl=%h required 1 aaaaaaaaaaaaaafb 01",
                  o_valid, o_data, o_ctrl);
      end
      i_ready = 1'b1;
      send_byte(TERM, 1'b1);
      for (int i = 0; i < 3; i++) send_byte(IDLE, 1'b1);
      test_drain("overflow");
      checks++;
      if (o_overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky got %b required 1", o_overflow);
      end
   endtask

   task automatic test_proto_err();
      expect_word(64'h070707070707FE55, 8'hFE);
      checks++;
      if (o_proto_err !== 1'b0) begin
         errors++;
         $display("FAIL proto_before got %b required 0", o_proto_err);
      end
      send_byte(8'h55, 1'b0);
      send_byte(8'h9C, 1'b1);
      for (int i = 0; i < 6; i++) send_byte(IDLE, 1'b1);
      test_drain("proto_err");
      checks++;
      if (o_proto_err !== 1'b1) begin
         errors++;
         $display("FAIL proto_after got %b required 1", o_proto_err);
      end
   endtask

   task automatic test_reset_mid_word();
      for (int i = 0; i < 3; i++) send_byte(IDLE, 1'b1);
      i_rst = 1'b1;
      #2;
      checks++;
      if ({o_valid, o_overflow, o_proto_err, o_ctrl} !== {3'b000, 8'hFF}) begin
         errors++;
         $display("FAIL mid_reset got v=%b ov=%b pe=%b ctrl=%h required 0 0 0 ff",
                  o_valid, o_overflow, o_proto_err, o_ctrl);
      end
      i_rst = 1'b0;
      wait_cycles(1);
      expect_word(64'hAAAAAAAAAAAAAAFB, 8'h01);
      send_byte(START, 1'b1);
      for (int i = 0; i < 7; i++) send_byte(8'hAA, 1'b0);
      test_drain("reset_mid_word");
      checks++;
      if (o_proto_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_proto got %b required 0", o_proto_err);
      end
   endtask

   initial begin
      wait_cycles(2);
      test_reset();
      i_rst = 1'b0;
      wait_cycles(1);
      test_idle_word();
      test_start_lane0();
      test_start_align();
      test_long_frame();
      test_back_to_back_overflow();
      test_proto_err();
      test_reset_mid_word();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
